// File: rtl/iob_eth_tx_pkg.sv
// rtl/iob_eth_tx_pkg.sv - shared types and constants for the Ethernet TX framer
//
// Contents:
//   tx_state_e    : framer FSM states
//   PREAMBLE_LEN  : number of 0x55 preamble bytes
//   PREAMBLE_BYTE : preamble byte value
//   SFD_BYTE      : start-of-frame delimiter value
//   FCS_LEN       : number of FCS bytes
//   fcs_from_crc  : maps the CRC register onto the on-line FCS word (byte k = bits 8k+7..8k)
package iob_eth_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        SFD,
        DATA,
        PAD,
        FCS,
        IFG
    } tx_state_e;

    localparam logic [10:0] PREAMBLE_LEN  = 11'd7;
    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [10:0] FCS_LEN       = 11'd4;

    // The CRC register is kept MSB-first, so the first FCS bit on the wire is
    // the inverted register MSB; bit i of byte k is ~crc[31-8k-i].
    function automatic logic [31:0] fcs_from_crc(input logic [31:0] crc);
        logic [31:0] w;
        for (int j = 0; j < 32; j++) begin
            w[j] = ~crc[31-j];
        end
        return w;
    endfunction

endpackage

// File: rtl/iob_eth_crc.sv
// rtl/iob_eth_crc.sv - byte-wide IEEE 802.3 CRC-32 accumulator
//
// Ports:
//   clk       : clock, rising edge
//   rst       : asynchronous active-high reset (register -> 0xFFFFFFFF)
//   start_i   : reinitialise the register to 0xFFFFFFFF
//   data_en_i : fold data_i into the register this cycle
//   data_i    : byte to fold, bit 0 first (line order)
//   crc_o     : current CRC register, MSB-first form
module iob_eth_crc (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        data_en_i,
    input  logic [7:0]  data_i,
    output logic [31:0] crc_o
);

    localparam logic [31:0] POLY = 32'h04C11DB7;

    logic [31:0] crc_q, crc_d;

    // Shifts one byte through the MSB-first LFSR, LSB of the byte first
    // since that is the order bits leave on the wire.
    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            r = {r[30:0], 1'b0} ^ ((r[31] ^ d[i]) ? POLY : 32'h0);
        end
        return r;
    endfunction

    always_comb begin
        crc_d = crc_q;
        if (start_i) begin
            crc_d = 32'hFFFF_FFFF;
        end else if (data_en_i) begin
            crc_d = crc_step(crc_q, data_i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc_q <= 32'hFFFF_FFFF;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/iob_eth_tx_framer.sv
// rtl/iob_eth_tx_framer.sv - Ethernet TX framer: preamble, SFD, payload, pad, FCS, IFG
//
// Ports:
//   clk      : clock, rising edge
//   rst      : asynchronous active-high reset
//   tx_start : one-cycle frame request, honoured only in IDLE
//   tx_len   : payload byte count, sampled with tx_start
//   s_data   : payload byte
//   s_valid  : s_data valid
//   s_ready  : payload byte accepted this cycle (DATA only)
//   tx_data  : registered line byte
//   tx_en    : registered line byte valid
//   busy     : FSM not in IDLE
//   done     : pulse on IDLE entry after a complete frame
//   err      : pulse on length reject or payload underrun
module iob_eth_tx_framer
    import iob_eth_tx_pkg::*;
#(
    parameter int IFG_CYCLES = 12,
    parameter int MIN_DATA   = 60,
    parameter int MAX_DATA   = 1514
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tx_start,
    input  logic [10:0] tx_len,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [7:0]  tx_data,
    output logic        tx_en,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam logic [10:0] MIN_W    = 11'(MIN_DATA);
    localparam logic [10:0] MAX_W    = 11'(MAX_DATA);
    localparam logic [10:0] IFG_LAST = 11'(IFG_CYCLES - 1);

    tx_state_e   state_q, state_d;
    logic [10:0] cnt_q, cnt_d;
    logic [10:0] len_q, len_d;
    logic [23:0] fcs_q, fcs_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_en_q, tx_en_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        good_q, good_d;

    logic        crc_start, crc_en;
    logic [31:0] crc_val, fcs_word;
    logic [10:0] cnt_inc;

    assign cnt_inc  = cnt_q + 11'd1;
    assign fcs_word = fcs_from_crc(crc_val);

    // The state names the byte being prepared this cycle; it reaches the
    // line one cycle later through the output registers. This lets DATA
    // accept a byte and put it on the line the next cycle without a bubble
    // after the SFD.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        fcs_d     = fcs_q;
        good_d    = good_q;
        tx_data_d = 8'h00;
        tx_en_d   = 1'b0;
        done_d    = 1'b0;
        err_d     = 1'b0;
        s_ready   = 1'b0;
        crc_start = 1'b0;
        crc_en    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (tx_start) begin
                    if (tx_len != 11'd0 && tx_len <= MAX_W) begin
                        // First preamble byte is prepared here for latency 1.
                        len_d     = tx_len;
                        cnt_d     = 11'd1;
                        tx_data_d = PREAMBLE_BYTE;
                        tx_en_d   = 1'b1;
                        state_d   = PRE;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            PRE: begin
                tx_data_d = PREAMBLE_BYTE;
                tx_en_d   = 1'b1;
                cnt_d     = cnt_inc;
                if (cnt_inc == PREAMBLE_LEN) begin
                    cnt_d   = 11'd0;
                    state_d = SFD;
                end
            end
            SFD: begin
                tx_data_d = SFD_BYTE;
                tx_en_d   = 1'b1;
                crc_start = 1'b1;
                state_d   = DATA;
            end
            DATA: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    tx_data_d = s_data;
                    tx_en_d   = 1'b1;
                    crc_en    = 1'b1;
                    cnt_d     = cnt_inc;
                    if (cnt_inc == len_q) begin
                        if (len_q < MIN_W) begin
                            state_d = PAD;
                        end else begin
                            cnt_d   = 11'd0;
                            state_d = FCS;
                        end
                    end
                end else begin
                    // Underrun: line goes quiet, frame is abandoned without FCS.
                    err_d   = 1'b1;
                    cnt_d   = 11'd0;
                    state_d = IFG;
                end
            end
            PAD: begin
                tx_en_d = 1'b1;
                crc_en  = 1'b1;
                cnt_d   = cnt_inc;
                if (cnt_inc == MIN_W) begin
                    cnt_d   = 11'd0;
                    state_d = FCS;
                end
            end
            FCS: begin
                tx_en_d = 1'b1;
                // The CRC register is final from the first FCS cycle on;
                // capture it once and shift the rest out of fcs_q.
                if (cnt_q == 11'd0) begin
                    tx_data_d = fcs_word[7:0];
                    fcs_d     = fcs_word[31:8];
                end else begin
                    tx_data_d = fcs_q[7:0];
                    fcs_d     = {8'h00, fcs_q[23:8]};
                end
                cnt_d = cnt_inc;
                if (cnt_inc == FCS_LEN) begin
                    cnt_d   = 11'd0;
                    good_d  = 1'b1;
                    state_d = IFG;
                end
            end
            IFG: begin
                cnt_d = cnt_inc;
                if (cnt_q == IFG_LAST) begin
                    cnt_d   = 11'd0;
                    done_d  = good_q;
                    good_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= 11'd0;
            len_q     <= 11'd0;
            fcs_q     <= 24'd0;
            good_q    <= 1'b0;
            tx_data_q <= 8'h00;
            tx_en_q   <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            fcs_q     <= fcs_d;
            good_q    <= good_d;
            tx_data_q <= tx_data_d;
            tx_en_q   <= tx_en_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    iob_eth_crc u_crc (
        .clk       (clk),
        .rst       (rst),
        .start_i   (crc_start),
        .data_en_i (crc_en),
        .data_i    (tx_data_d),
        .crc_o     (crc_val)
    );

    assign tx_data = tx_data_q;
    assign tx_en   = tx_en_q;
    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign err     = err_q;

endmodule

// File: tb/tb_iob_eth_tx_framer.sv
// tb/tb_iob_eth_tx_framer.sv - directed self-checking bench for iob_eth_tx_framer
module tb_iob_eth_tx_framer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tx_start = 1'b0;
    logic [10:0] tx_len = 11'd0;
    logic [7:0]  s_data = 8'h00;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [7:0]  tx_data;
    logic        tx_en;
    logic        busy;
    logic        done;
    logic        err;

    iob_eth_tx_framer dut (
        .clk      (clk),
        .rst      (rst),
        .tx_start (tx_start),
        .tx_len   (tx_len),
        .s_data   (s_data),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .tx_data  (tx_data),
        .tx_en    (tx_en),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0] cap[$];
    int en_cycles, low_total, busy_low, err_pulses, err_at, done_seen, done_low, gaps, idx;
    logic ended;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pay(input int i, input int len);
        return 8'((i * 37 + len * 3 + 1) & 255);
    endfunction

    // Expected line byte i of a frame: preamble, SFD, payload, zero pad.
    function automatic logic [7:0] exp_byte(input int i, input int len);
        if (i < 7) return 8'h55;
        if (i == 7) return 8'hD5;
        if (i - 8 < len) return pay(i - 8, len);
        return 8'h00;
    endfunction

    // Reflected IEEE 802.3 CRC-32 over payload plus pad; result is the value
    // whose byte 0 goes on the line first.
    function automatic logic [31:0] fcs_model(input int len);
        logic [31:0] c;
        int n;
        c = 32'hFFFF_FFFF;
        n = (len < 60) ? 60 : len;
        for (int i = 0; i < n; i++) begin
            c = c ^ {24'h0, (i < len) ? pay(i, len) : 8'h00};
            for (int b = 0; b < 8; b++) begin
                c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
            end
        end
        return ~c;
    endfunction

    function automatic int count_mism(input int n, input int len);
        int m;
        m = 0;
        for (int i = 0; i < n; i++) begin
            if (i >= cap.size() || cap[i] !== exp_byte(i, len)) m++;
        end
        return m;
    endfunction

    // Requests a frame and runs it to IDLE, optionally dropping s_valid at
    // payload byte drop_at, asserting rst at payload byte rst_at, or pulsing
    // a stray tx_start once en_cycles reaches mid_start_at.
    task automatic run(input int len, input int drop_at, input int rst_at, input int mid_start_at);
        cap.delete();
        en_cycles = 0; low_total = 0; busy_low = 0; err_pulses = 0; err_at = -1;
        done_seen = 0; done_low = -1; gaps = 0; idx = 0; ended = 1'b0;
        @(negedge clk);
        tx_start = 1'b1;
        tx_len   = 11'(len);
        s_valid  = 1'b1;
        s_data   = pay(0, len);
        @(posedge clk);
        @(negedge clk);
        tx_start = 1'b0;
        for (int c = 0; c < 2000 && !ended; c++) begin
            if (tx_en) begin
                if (low_total > 0) gaps++;
                cap.push_back(tx_data);
                en_cycles++;
            end else if (en_cycles > 0) begin
                low_total++;
                if (busy) busy_low++;
            end
            if (err) begin
                err_pulses++;
                err_at = low_total;
            end
            if (done) begin
                done_seen++;
                done_low = low_total;
            end
            if (!busy) begin
                ended = 1'b1;
            end else if (rst_at >= 0 && s_ready && idx == rst_at) begin
                rst = 1'b1;
                #1;
                check("rst_async_outputs", {tx_en, tx_data, s_ready, busy, done, err}, 64'd0);
                @(posedge clk);
                @(negedge clk);
                rst   = 1'b0;
                ended = 1'b1;
            end else begin
                s_valid = !(drop_at >= 0 && idx == drop_at);
                s_data  = pay(idx, len);
                if (mid_start_at >= 0 && en_cycles == mid_start_at) begin
                    tx_start = 1'b1;
                    tx_len   = 11'd5;
                end else begin
                    tx_start = 1'b0;
                end
                if (s_ready && s_valid) idx++;
                @(posedge clk);
                @(negedge clk);
            end
        end
        tx_start = 1'b0;
        if (!ended) check("run_timeout", 64'd1, 64'd0);
    endtask

    task automatic check_good(input int len);
        int n;
        n = (len < 60) ? 60 : len;
        check($sformatf("len%0d_en_cycles", len), 64'(en_cycles), 64'(n + 12));
        check($sformatf("len%0d_en_gaps", len), 64'(gaps), 64'd0);
        check($sformatf("len%0d_byte_mismatches", len), 64'(count_mism(n + 8, len)), 64'd0);
        check($sformatf("len%0d_fcs", len),
              {32'd0, cap[n + 11], cap[n + 10], cap[n + 9], cap[n + 8]}, {32'd0, fcs_model(len)});
        check($sformatf("len%0d_done_count", len), 64'(done_seen), 64'd1);
        check($sformatf("len%0d_done_after_low", len), 64'(done_low), 64'd12);
        check($sformatf("len%0d_err_count", len), 64'(err_pulses), 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_outputs", {tx_en, tx_data, s_ready, busy, done, err}, 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_after_reset", {tx_en, busy, done, err}, 64'd0);

        run(100, -1, -1, -1);
        check_good(100);
        run(10, -1, -1, -1);
        check_good(10);
        run(60, -1, -1, 30);
        check_good(60);
        run(1514, -1, -1, -1);
        check_good(1514);

        run(100, 20, -1, -1);
        check("underrun_en_cycles", 64'(en_cycles), 64'd28);
        check("underrun_bytes", 64'(count_mism(28, 100)), 64'd0);
        check("underrun_err_count", 64'(err_pulses), 64'd1);
        check("underrun_err_at_fall", 64'(err_at), 64'd1);
        check("underrun_busy_low", 64'(busy_low), 64'd12);
        check("underrun_no_done", 64'(done_seen), 64'd0);

        run(0, -1, -1, -1);
        check("len0_err_count", 64'(err_pulses), 64'd1);
        check("len0_no_tx", 64'(en_cycles), 64'd0);
        check("len0_busy", {63'd0, busy}, 64'd0);
        run(1515, -1, -1, -1);
        check("len1515_err_count", 64'(err_pulses), 64'd1);
        check("len1515_no_tx", 64'(en_cycles), 64'd0);
        check("len1515_busy", {63'd0, busy}, 64'd0);

        run(100, -1, 30, -1);
        check("rst_released_outputs", {tx_en, tx_data, s_ready, busy, done, err}, 64'd0);
        check("rst_no_err", 64'(err_pulses), 64'd0);
        check("rst_no_done", 64'(done_seen), 64'd0);
        check("rst_bytes_before", 64'(count_mism(38, 100)), 64'd0);

        run(64, -1, -1, -1);
        check_good(64);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
